// File: rtl/timer_types_pkg.sv
// timer_types_pkg: default widths and the largest prescale ratio shared by the timer blocks
package timer_types_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int PRE_W_DEF = 3;
  localparam int PS_MAX_RATIO = 1 << ((1 << PRE_W_DEF) - 1);
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: 2^pre divider (clk, rst, en, clr, pre in; tick out), cleared on clr or a change of pre
module timer_prescaler
  import timer_types_pkg::*;
#(
  parameter int PRE_W = PRE_W_DEF,
  localparam int PS_W = (1 << PRE_W) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);
  logic [PS_W-1:0] cnt_q, cnt_d, mask;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic pre_chg;
  always_comb begin
    mask = PS_W'((32'd1 << pre) - 32'd1);
    pre_chg = pre != pre_q;
    pre_d = pre;
    tick = en & ~clr & ~pre_chg & ~rst & (cnt_q == mask);
    cnt_d = (clr | pre_chg | tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pre_q <= pre_d;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end
endmodule

// File: rtl/timer_counter.sv
// timer_counter: prescaled up-counter TCNT (CLK, RST, tcren, pre, tcre, ch7_match, tcnt_wr/tcnt_wdata, tovf_clr, toi in; tcnt, tick, tovf, ovf_irq out; freeze in when TIMER_FREEZE_EN)
module timer_counter
  import timer_types_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tcren,
  input  logic [PRE_W-1:0] pre,
  input  logic             tcre,
  input  logic             ch7_match,
  input  logic             tcnt_wr,
  input  logic [CNT_W-1:0] tcnt_wdata,
  input  logic             tovf_clr,
  input  logic             toi,
`ifdef TIMER_FREEZE_EN
  input  logic             freeze,
`endif
  output logic [CNT_W-1:0] tcnt,
  output logic             tick,
  output logic             tovf,
  output logic             ovf_irq
);
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic tovf_q, tovf_d, en, tcre_hit, tovf_set;
`ifdef TIMER_FREEZE_EN
  assign en = tcren & ~freeze;
`else
  assign en = tcren;
`endif
  timer_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk (CLK),
    .rst (RST),
    .en  (en),
    .clr (tcnt_wr),
    .pre (pre),
    .tick(tick)
  );
  always_comb begin
    tcre_hit = tcre & ch7_match;
    tovf_set = tick & ~tcre_hit & (&tcnt_q);
    tcnt_d = tcnt_wr ? tcnt_wdata : ~tick ? tcnt_q : tcre_hit ? '0 : tcnt_q + 1'b1;
    tovf_d = tovf_set | (tovf_q & ~tovf_clr);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt_q <= '0;
      tovf_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tovf_q <= tovf_d;
    end
  end
  assign tcnt = tcnt_q;
  assign tovf = tovf_q;
  assign ovf_irq = tovf_q & toi & ~RST;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed self-checking bench for timer_counter
module tb_timer_counter;
  logic CLK = 1'b0;
  logic RST, tcren, tcre, ch7_match, tcnt_wr, tovf_clr, toi;
  logic [2:0] pre;
  logic [31:0] tcnt_wdata, tcnt;
  logic tick, tovf, ovf_irq;
  int checks = 0;
  int errors = 0;
  int ticks_seen;
  always #5 CLK = ~CLK;
  timer_counter dut (
    .CLK(CLK), .RST(RST), .tcren(tcren), .pre(pre), .tcre(tcre),
    .ch7_match(ch7_match), .tcnt_wr(tcnt_wr), .tcnt_wdata(tcnt_wdata),
    .tovf_clr(tovf_clr), .toi(toi),
    .tcnt(tcnt), .tick(tick), .tovf(tovf), .ovf_irq(ovf_irq)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    RST = 1; tcren = 1; pre = 3'd2; tcre = 0; ch7_match = 0;
    tcnt_wr = 0; tcnt_wdata = '0; tovf_clr = 0; toi = 1;
    #1;
    check("tick_in_reset", 32'(tick), 0);
    check("irq_in_reset", 32'(ovf_irq), 0);
    step();
    check("rst_tcnt", tcnt, 0);
    check("rst_tovf", 32'(tovf), 0);
    RST = 0; toi = 0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      check($sformatf("pre2_tick_c%0d", c), 32'(tick), 32'(c % 4 == 0));
      step();
    end
    check("pre2_tcnt", tcnt, 3);
    tcnt_wr = 1; tcnt_wdata = 32'hFFFF_FFFE; pre = 3'd0;
    #1;
    check("wr_no_tick", 32'(tick), 0);
    step();
    tcnt_wr = 0;
    check("wr_load", tcnt, 32'hFFFF_FFFE);
    step();
    check("inc_ffff", tcnt, 32'hFFFF_FFFF);
    step();
    check("wrap_tcnt", tcnt, 0);
    check("wrap_tovf", 32'(tovf), 1);
    check("irq_off", 32'(ovf_irq), 0);
    toi = 1;
    #1;
    check("irq_on", 32'(ovf_irq), 1);
    tcren = 0; tcnt_wr = 1; tcnt_wdata = 32'hFFFF_FFFF; tovf_clr = 1;
    step();
    tcnt_wr = 0;
    check("clr_tovf", 32'(tovf), 0);
    tcren = 1;
    step();
    check("coll_wrap", tcnt, 0);
    check("coll_set_wins", 32'(tovf), 1);
    tcren = 0;
    step();
    tovf_clr = 0;
    check("clr_alone", 32'(tovf), 0);
    check("irq_cleared", 32'(ovf_irq), 0);
    check("hold_tick", 32'(tick), 0);
    step(); step();
    check("hold_tcnt", tcnt, 0);
    tcnt_wr = 1; tcnt_wdata = 32'h10; tcren = 1; tcre = 1;
    step();
    tcnt_wr = 0; ch7_match = 1;
    #1;
    check("tcre_tick", 32'(tick), 1);
    step();
    check("tcre_tcnt", tcnt, 0);
    check("tcre_tovf", 32'(tovf), 0);
    tcre = 0;
    step();
    ch7_match = 0;
    check("ch7_no_tcre", tcnt, 1);
    pre = 3'd1;
    step();
    #1;
    check("pre1_c0", 32'(tick), 0);
    step();
    check("pre1_c1", 32'(tick), 1);
    tcnt_wr = 1; tcnt_wdata = 32'h55; tcre = 1; ch7_match = 1;
    #1;
    check("prio_no_tick", 32'(tick), 0);
    step();
    tcnt_wr = 0; tcre = 0; ch7_match = 0;
    check("prio_tcnt", tcnt, 32'h55);
    check("prio_ps_clr", 32'(tick), 0);
    step();
    check("prio_ps_next", 32'(tick), 1);
    step();
    check("prio_inc", tcnt, 32'h56);
    pre = 3'd0;
    #1;
    check("prechg_no_tick", 32'(tick), 0);
    step();
    check("prechg_hold", tcnt, 32'h56);
    check("prechg_after", 32'(tick), 1);
    pre = 3'd7;
    step();
    for (int i = 0; i < 64; i++) step();
    RST = 1; tcnt_wr = 1; tcnt_wdata = 32'hABCD; tovf_clr = 1;
    #1;
    check("midrst_tick", 32'(tick), 0);
    step();
    RST = 0; tcnt_wr = 0; tovf_clr = 0;
    check("midrst_tcnt", tcnt, 0);
    ticks_seen = 0;
    for (int i = 0; i < 127; i++) begin
      #1;
      if (tick) ticks_seen++;
      step();
    end
    check("midrst_no_early_tick", 32'(ticks_seen), 0);
    check("midrst_tick128", 32'(tick), 1);
    step();
    check("midrst_tcnt1", tcnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL take parameter CNT_W, default 32, main counter width (matches the TCNT register).
REQ-002 The block SHALL take parameter PRE_W, default 3, prescale select width (matches TSCR2.PRE).
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 tcren  input  1  counter enable (TSCR.TCREN).
REQ-006 pre  input  PRE_W  prescale select; divide ratio is 2^pre.
REQ-007 tcre  input  1  reset counter on channel-7 compare (TSCR2.TCRE).
REQ-008 ch7_match  input  1  single-cycle compare-match pulse from channel 7.
REQ-009 tcnt_wr  input  1  APB write strobe to TCNT.
REQ-010 tcnt_wdata  input  CNT_W  write data for TCNT.
REQ-011 tovf_clr  input  1  write-1-to-clear strobe for FLG2.TOVF.
REQ-012 toi  input  1  overflow interrupt enable (TSCR2.TOI).
REQ-013 tcnt  output  CNT_W  current counter value.
REQ-014 tick  output  1  one-cycle pulse on every cycle in which tcnt advances.
REQ-015 tovf  output  1  sticky overflow flag (FLG2.TOVF).
REQ-016 ovf_irq  output  1  overflow interrupt request.

Function
REQ-017 The prescaler SHALL be a 2^PRE_W-1-bit up-counter that advances only while tcren=1.
REQ-018 tick SHALL be asserted combinationally when tcren=1 and the prescaler equals 2^pre-1; the prescaler SHALL wrap to 0 in that cycle.
REQ-019 With pre=0, tick SHALL assert on every enabled cycle.
REQ-020 A change of pre SHALL clear the prescaler on the following edge and suppress tick for that cycle.
REQ-021 With tcren=0, the prescaler and tcnt SHALL hold and tick SHALL be 0.
REQ-022 On tick with tcnt=all-ones, tcnt SHALL wrap to 0 and tovf SHALL be set on the same edge.
REQ-023 On tick with tcre=1 and ch7_match=1, tcnt SHALL load 0 and SHALL NOT set tovf.
REQ-024 tcnt update priority SHALL be: RST > tcnt_wr > TCRE reset > increment.
REQ-025 tcnt_wr SHALL load tcnt_wdata, clear the prescaler, and suppress tick in that cycle.
REQ-026 When a tovf set and tovf_clr occur in the same cycle, tovf SHALL end that edge set; set wins.
REQ-027 ovf_irq SHALL equal tovf AND toi, combinationally, with no added latency.
REQ-028 Latency from a tick cycle to the updated tcnt SHALL be exactly one clock.

Reset
REQ-029 On RST=1 at a rising edge, tcnt, the prescaler and tovf SHALL be 0.
REQ-030 Reset SHALL override every in-progress prescale period and every simultaneous strobe.
REQ-031 tick and ovf_irq SHALL be 0 while RST=1.

Configuration
REQ-032 Macro TIMER_FREEZE_EN, when defined, SHALL add input freeze (1 bit, debug halt); while freeze=1, the prescaler, tcnt and tick SHALL behave as if tcren=0, but tcnt_wr and tovf_clr SHALL still act.
REQ-033 When TIMER_FREEZE_EN is not defined, the freeze port SHALL NOT exist and behaviour SHALL be as in REQ-017 to REQ-031.

Structure
REQ-034 The constants for CNT_W and PRE_W defaults, and the maximum prescale ratio, SHALL live in timer_types_pkg.
REQ-035 The prescaler (REQ-017 to REQ-021) SHALL be the sub-module timer_prescaler, which outputs tick; timer_counter SHALL instantiate it once.

Verification
REQ-036 Prescale: tcren=1, pre=2, run 12 cycles from reset -> tick on cycles 4, 8 and 12; tcnt=3.
REQ-037 Overflow: tcnt_wr with 0xFFFF_FFFE, pre=0, 2 cycles -> tcnt=0, tovf=1; toi=1 -> ovf_irq=1.
REQ-038 TCRE: tcre=1, tcnt=0x10, ch7_match pulse coincident with tick -> tcnt=0, tovf unchanged at 0.
REQ-039 Flag collision: tovf_clr asserted in the same cycle as a wrap -> tovf remains 1; tovf_clr alone next cycle -> tovf=0.
REQ-040 Priority: tcnt_wr=0x55 in the same cycle as a tick with tcre/ch7_match -> tcnt=0x55, prescaler=0.
REQ-041 Reset mid-operation: RST pulsed while pre=7 and prescaler=0x40 -> tcnt=0, no tick until 128 enabled cycles later.
